// File: rtl/si5341_cfg_seq.sv
// Si5341 configuration sequencer: walks a register table, inserts page
// writes, runs embedded ms delays, and feeds three-byte frames to i2c_ctrl.
module si5341_cfg_seq #(
   parameter int          SYS_CLK  = 50_000_000,
   parameter int          MS_CYC   = 50_000,
   parameter logic [7:0]  DEV_ADDR = 8'hE8,
   parameter logic [15:0] TBL_LEN  = 16'd512,
   parameter int          AW       = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic [AW-1:0] tbl_addr,
   input  logic [23:0]   tbl_data,
   output logic          wr_req,
   output logic [7:0]    wr_data,
   input  logic          wr_done,
   output logic          busy,
   output logic          cfg_done
);

   // Fall back to SYS_CLK/1000 if no explicit cycles-per-ms is given.
   localparam logic [31:0] MsCyc =
      (MS_CYC > 0) ? 32'(MS_CYC) : 32'(SYS_CLK / 1000);
   localparam logic [AW-1:0] LastAddr = AW'(TBL_LEN - 16'd1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_PAGE_WR,
      S_REG_WR,
      S_GAP,
      S_DELAY,
      S_NEXT,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [23:0]   ent_q, ent_d;
   logic [7:0]    page_q, page_d;
   logic          pv_q, pv_d;
   logic [1:0]    bcnt_q, bcnt_d;
   logic          gap_q, gap_d;
   logic          to_reg_q, to_reg_d;
   logic [31:0]   dly_q, dly_d;
   logic          req_q, req_d;
   logic [7:0]    data_q, data_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [1:0]    bnext;
   logic          is_pg;

   assign bnext = bcnt_q + 2'd1;
   assign is_pg = (state_q == S_PAGE_WR);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         ent_q    <= '0;
         page_q   <= '0;
         pv_q     <= 1'b0;
         bcnt_q   <= '0;
         gap_q    <= 1'b0;
         to_reg_q <= 1'b0;
         dly_q    <= '0;
         req_q    <= 1'b0;
         data_q   <= 8'h00;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         ent_q    <= ent_d;
         page_q   <= page_d;
         pv_q     <= pv_d;
         bcnt_q   <= bcnt_d;
         gap_q    <= gap_d;
         to_reg_q <= to_reg_d;
         dly_q    <= dly_d;
         req_q    <= req_d;
         data_q   <= data_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      ent_d    = ent_q;
      page_d   = page_q;
      pv_d     = pv_q;
      bcnt_d   = bcnt_q;
      gap_d    = gap_q;
      to_reg_d = to_reg_q;
      dly_d    = dly_q;
      req_d    = req_q;
      data_d   = data_q;
      busy_d   = busy_q;
      done_d   = done_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d  = '0;
               pv_d    = 1'b0;
               done_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            ent_d = tbl_data;
            if (tbl_data[23:8] == 16'hFFFF) begin
               if (tbl_data[7:0] == 8'h00) begin
                  state_d = S_NEXT;
               end else begin
                  dly_d   = 32'(tbl_data[7:0]) * MsCyc - 32'd1;
                  state_d = S_DELAY;
               end
            end else begin
               req_d  = 1'b1;
               data_d = DEV_ADDR;
               bcnt_d = 2'd0;
               if (!pv_q || tbl_data[23:16] != page_q) begin
                  state_d = S_PAGE_WR;
               end else begin
                  state_d = S_REG_WR;
               end
            end
         end
         S_PAGE_WR, S_REG_WR: begin
            if (wr_done) begin
               if (bcnt_q == 2'd2) begin
                  req_d    = 1'b0;
                  gap_d    = 1'b0;
                  to_reg_d = is_pg;
                  state_d  = S_GAP;
                  if (is_pg) begin
                     page_d = ent_q[23:16];
                     pv_d   = 1'b1;
                  end
               end else begin
                  bcnt_d = bnext;
                  if (is_pg) begin
                     data_d = (bnext == 2'd1) ? 8'h01 : ent_q[23:16];
                  end else begin
                     data_d = (bnext == 2'd1) ? ent_q[15:8] : ent_q[7:0];
                  end
               end
            end
         end
         S_GAP: begin
            // Two idle cycles let i2c_ctrl emit STOP before the next frame.
            if (gap_q) begin
               if (to_reg_q) begin
                  req_d   = 1'b1;
                  data_d  = DEV_ADDR;
                  bcnt_d  = 2'd0;
                  state_d = S_REG_WR;
               end else begin
                  state_d = S_NEXT;
               end
            end else begin
               gap_d = 1'b1;
            end
         end
         S_DELAY: begin
            if (dly_q == 32'd0) begin
               state_d = S_NEXT;
            end else begin
               dly_d = dly_q - 32'd1;
            end
         end
         S_NEXT: begin
            if (addr_q == LastAddr) begin
               state_d = S_DONE;
            end else begin
               addr_d  = addr_q + 1'b1;
               state_d = S_FETCH;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign tbl_addr = addr_q;
   assign wr_req   = req_q;
   assign wr_data  = data_q;
   assign busy     = busy_q;
   assign cfg_done = done_q;

endmodule

// File: tb/tb_si5341_cfg_seq.sv
// Bench for si5341_cfg_seq: registered ROM, i2c_ctrl responder,
// and a frame-level reference model of the expected byte stream.
module tb_si5341_cfg_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] tbl_addr;
   logic [23:0] tbl_data;
   logic        wr_req;
   logic [7:0]  wr_data;
   logic        wr_done;
   logic        busy;
   logic        cfg_done;

   logic [23:0] tbl [3];
   int          errs = 0;
   int          checks = 0;
   int          cyc = 0;
   int          lat = 20;
   int          done_edge = 0;
   int          cnt = 0;
   int          lowrun = 0;
   logic [7:0]  got [$];
   int          gaps [$];
   logic [7:0]  exp_b [$];
   int          kinds [$];

   si5341_cfg_seq #(
      .MS_CYC (10),
      .TBL_LEN(16'd3)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .tbl_addr(tbl_addr),
      .tbl_data(tbl_data),
      .wr_req  (wr_req),
      .wr_data (wr_data),
      .wr_done (wr_done),
      .busy    (busy),
      .cfg_done(cfg_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk)
      tbl_data <= (tbl_addr < 16'd3) ? tbl[tbl_addr[1:0]] : 24'h0;

   // i2c_ctrl stand-in: acks each byte lat cycles after it appears.
   initial begin
      wr_done = 1'b0;
      forever begin
         @(negedge clk);
         if (wr_req) begin
            if (lowrun > 0) gaps.push_back(lowrun);
            lowrun = 0;
         end else begin
            lowrun++;
         end
         if (wr_done || !wr_req || rst) begin
            wr_done = 1'b0;
            cnt = 0;
         end else begin
            cnt++;
            if (cnt >= lat) begin
               wr_done = 1'b1;
               got.push_back(wr_data);
               done_edge = cyc + 1;
            end
         end
      end
   end

   task automatic build_model();
      bit         pv;
      logic [7:0] pg;
      logic [15:0] a;
      pv = 0;
      pg = 8'h00;
      exp_b.delete();
      kinds.delete();
      for (int i = 0; i < 3; i++) begin
         a = tbl[i][23:8];
         if (a != 16'hFFFF) begin
            if (!pv || a[15:8] != pg) begin
               exp_b.push_back(8'hE8);
               exp_b.push_back(8'h01);
               exp_b.push_back(a[15:8]);
               kinds.push_back(1);
               pg = a[15:8];
               pv = 1;
            end
            exp_b.push_back(8'hE8);
            exp_b.push_back(a[7:0]);
            exp_b.push_back(tbl[i][7:0]);
            kinds.push_back(0);
         end
      end
   endtask

   task automatic run(input bit mid, input string nm, output int len);
      int b0, g0, t0, w, bad, nb, ng, gv;
      bit pulsed;
      build_model();
      b0 = got.size();
      g0 = gaps.size();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t0 = cyc;
      checks++;
      if (busy !== 1'b1 || tbl_addr !== 16'd0 || cfg_done !== 1'b0) begin
         errs++;
         $display("FAIL %s_start: busy=%b addr=%0d cfg_done=%b want 1,0,0",
                  nm, busy, tbl_addr, cfg_done);
      end
      @(negedge clk);
      @(negedge clk);
      if (tbl[0][23:8] != 16'hFFFF) begin
         checks++;
         if (wr_req !== 1'b1 || wr_data !== 8'hE8) begin
            errs++;
            $display("FAIL %s_first: wr_req=%b wr_data=%h want 1,e8",
                     nm, wr_req, wr_data);
         end
      end
      w = 0;
      pulsed = 0;
      while (!cfg_done && w < 5000) begin
         @(negedge clk);
         w++;
         start = mid && !pulsed && wr_req && (got.size() == b0 + 4);
         if (start) pulsed = 1;
      end
      start = 1'b0;
      len = cyc - t0;
      checks++;
      if (!cfg_done) begin
         errs++;
         $display("FAIL %s_timeout: cfg_done=%b after %0d cycles want 1",
                  nm, cfg_done, w);
         return;
      end
      checks++;
      if (busy !== 1'b0 || cyc + 1 - done_edge != 5) begin
         errs++;
         $display("FAIL %s_end: busy=%b done_lat=%0d want 0,5",
                  nm, busy, cyc + 1 - done_edge);
      end
      nb = got.size() - b0;
      bad = 0;
      for (int i = 0; i < nb && i < exp_b.size(); i++)
         if (got[b0+i] !== exp_b[i]) bad++;
      checks++;
      if (nb != exp_b.size() || bad != 0) begin
         errs++;
         $display("FAIL %s_bytes: got %0d bytes %0d wrong, want %0d bytes",
                  nm, nb, bad, exp_b.size());
      end
      ng = gaps.size() - g0;
      bad = 0;
      for (int k = 1; k < ng && k < kinds.size(); k++) begin
         gv = gaps[g0+k];
         if (kinds[k-1] == 1 && kinds[k] == 0) begin
            if (gv != 2) bad++;
         end else if (gv < 2) begin
            bad++;
         end
      end
      checks++;
      if (ng != kinds.size() || bad != 0) begin
         errs++;
         $display("FAIL %s_gaps: frames=%0d bad_gaps=%0d want frames=%0d bad=0",
                  nm, ng, bad, kinds.size());
      end
   endtask

   task automatic set_basic();
      tbl[0] = 24'h0B24C0;
      tbl[1] = 24'h0B2500;
      tbl[2] = 24'h0A0301;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      set_basic();
      repeat (3) @(negedge clk);
      checks++;
      if (wr_req !== 1'b0 || wr_data !== 8'h00 || tbl_addr !== 16'd0 ||
          busy !== 1'b0 || cfg_done !== 1'b0) begin
         errs++;
         $display("FAIL reset: req=%b data=%h addr=%0d busy=%b done=%b want 0",
                  wr_req, wr_data, tbl_addr, busy, cfg_done);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int l;
      set_basic();
      run(0, "basic", l);
   endtask

   task automatic test_restart();
      int l;
      set_basic();
      run(0, "restart", l);
   endtask

   task automatic test_mid_start();
      int l;
      set_basic();
      run(1, "mid_start", l);
   endtask

   task automatic test_rst_mid();
      int b0, w, l;
      set_basic();
      b0 = got.size();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      w = 0;
      while (got.size() < b0 + 2 && w < 2000) begin
         @(negedge clk);
         w++;
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (w >= 2000 || wr_req !== 1'b0 || tbl_addr !== 16'd0 ||
          busy !== 1'b0 || cfg_done !== 1'b0) begin
         errs++;
         $display("FAIL rst_mid: req=%b addr=%0d busy=%b done=%b w=%0d want 0",
                  wr_req, tbl_addr, busy, cfg_done, w);
      end
      @(negedge clk);
      run(0, "after_rst", l);
   endtask

   task automatic test_delay();
      int l3, l0;
      tbl[0] = 24'h0B24C0;
      tbl[1] = 24'hFFFF03;
      tbl[2] = 24'h0B2500;
      run(0, "delay3", l3);
      tbl[1] = 24'hFFFF00;
      run(0, "delay0", l0);
      checks++;
      if (l3 - l0 != 30) begin
         errs++;
         $display("FAIL delay_len: extra=%0d cycles want 30", l3 - l0);
      end
   endtask

   task automatic test_random();
      int l;
      logic [7:0] pg;
      for (int n = 0; n < 4; n++) begin
         lat = $urandom_range(25, 1);
         for (int i = 0; i < 3; i++) begin
            pg = 8'h0A + 8'($urandom_range(2, 0));
            tbl[i] = {pg, 8'($urandom), 8'($urandom)};
            if (i > 0 && $urandom_range(4, 0) == 0)
               tbl[i] = {16'hFFFF, 8'($urandom_range(2, 0))};
         end
         run(0, "random", l);
      end
      lat = 20;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_restart();
      test_mid_start();
      test_rst_mid();
      test_delay();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
